// File: rtl/power_integrator_pkg.sv
// rtl/power_integrator_pkg.sv - shared types, constants and saturating add for the power integrator
//
// Contents:
//   state_t     FSM states ACCUM / LOAD / DRAIN
//   NUM_LANES   lanes per column (4)
//   lane_vec_t  4-lane vector at the default accumulator width
//   sat_add     unsigned add clamped to 2**width-1 (width <= SAT_MAX_W-1)
package integrator_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_LOAD,
        ST_DRAIN
    } state_t;

    localparam int NUM_LANES     = 4;
    localparam int DEF_ACC_WIDTH = 64;
    localparam int SAT_MAX_W     = 128;

    typedef logic [NUM_LANES-1:0][DEF_ACC_WIDTH-1:0] lane_vec_t;

    // Operands are carried at SAT_MAX_W bits so one function serves every
    // accumulator width; the carry-out bit catches wrap of the full sum.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int                   width
    );
        logic [SAT_MAX_W:0]   sum;
        logic [SAT_MAX_W-1:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        if (sum[SAT_MAX_W] || (sum[SAT_MAX_W-1:0] > lim)) begin
            return lim;
        end
        return sum[SAT_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/power_integrator_acc.sv
// rtl/power_integrator_acc.sv - per-lane overwrite-or-saturating-add cell
//
// Ports:
//   clear   1          first frame of a period: ignore the stored entry
//   entry   ACC_WIDTH  current accumulator value
//   addend  ADD_WIDTH  value to accumulate (may be a col1+col2 sum)
//   result  ACC_WIDTH  value to write back
module acc_lane_sat
    import integrator_pkg::*;
#(
    parameter int ADD_WIDTH = 54,
    parameter int ACC_WIDTH = 64
) (
    input  logic                 clear,
    input  logic [ACC_WIDTH-1:0] entry,
    input  logic [ADD_WIDTH-1:0] addend,
    output logic [ACC_WIDTH-1:0] result
);

    logic [ACC_WIDTH-1:0] base;

    // The overwrite path also saturates, so a collision sum wider than the
    // accumulator still clamps instead of wrapping.
    always_comb begin
        base   = clear ? '0 : entry;
        result = ACC_WIDTH'(sat_add(SAT_MAX_W'(base), SAT_MAX_W'(addend), ACC_WIDTH));
    end

endmodule

// File: rtl/power_integrator.sv
// rtl/power_integrator.sv - per-column, per-lane power accumulator with handshake drain
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid                       input beat strobe (no backpressure)
//   in_col1, in_col2               4-lane power words
//   in_index_col1, in_index_col2   column indices of the two words
//   out_valid, out_ready           drain handshake
//   out_data, out_index, out_last  drained column, its index, last-column flag
//   drop_err, clr_err              sticky discard flag and its synchronous clear
//   frame_cnt                      frames completed in the current period
module power_integrator
    import integrator_pkg::*;
#(
    parameter int IN_WIDTH  = 53,
    parameter int ACC_WIDTH = 64,
    parameter int IDX_WIDTH = 11,
    parameter int N_COLS    = 64,
    parameter int N_FRAMES  = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic [NUM_LANES-1:0][IN_WIDTH-1:0]   in_col1,
    input  logic [NUM_LANES-1:0][IN_WIDTH-1:0]   in_col2,
    input  logic [IDX_WIDTH-1:0]                 in_index_col1,
    input  logic [IDX_WIDTH-1:0]                 in_index_col2,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [NUM_LANES-1:0][ACC_WIDTH-1:0]  out_data,
    output logic [IDX_WIDTH-1:0]                 out_index,
    output logic                                 out_last,
    output logic                                 drop_err,
    input  logic                                 clr_err,
    output logic [$clog2(N_FRAMES+1)-1:0]        frame_cnt
);

    localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int FW = $clog2(N_FRAMES + 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_COLS - 1);
    localparam logic [IDX_WIDTH-1:0] GATE_IDX = IDX_WIDTH'(2);
    localparam logic [CW-1:0]        LAST_PTR = CW'(N_COLS - 1);

    state_t state_q, state_d;
    logic [NUM_LANES-1:0][ACC_WIDTH-1:0] mem [N_COLS];
    logic [NUM_LANES-1:0][ACC_WIDTH-1:0] res1, res2, data_q;
    logic [NUM_LANES-1:0][IN_WIDTH:0]    add1, add2;
    logic [CW-1:0] addr1, addr2, ptr_q, ptr_next;
    logic [FW-1:0] frame_q;
    logic ok1, en2, ok2, collide, accum_beat, wr1, wr2, bad_idx, frame_end;
    logic drop_set, load_first, advance, finish, clear;

    // Column 2 is only meaningful once column 1 has moved past index 1.
    assign ok1        = in_index_col1 <= LAST_IDX;
    assign en2        = in_index_col1 >= GATE_IDX;
    assign ok2        = en2 && (in_index_col2 <= LAST_IDX);
    assign collide    = ok1 && ok2 && (in_index_col1 == in_index_col2);
    assign accum_beat = in_valid && (state_q == ST_ACCUM);
    assign wr1        = accum_beat && ok1;
    assign wr2        = accum_beat && ok2 && !collide;
    assign bad_idx    = !ok1 || (en2 && !ok2);
    assign frame_end  = (ok1 && in_index_col1 == LAST_IDX) || (ok2 && in_index_col2 == LAST_IDX);
    assign addr1      = in_index_col1[CW-1:0];
    assign addr2      = in_index_col2[CW-1:0];
    assign clear      = (frame_q == '0);
    assign drop_set   = in_valid && ((state_q != ST_ACCUM) || bad_idx);
    assign ptr_next   = ptr_q + CW'(1);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        // On a collision the col2 word folds into the col1 write port.
        assign add1[l] = {1'b0, in_col1[l]} + (collide ? {1'b0, in_col2[l]} : '0);
        assign add2[l] = {1'b0, in_col2[l]};

        acc_lane_sat #(.ADD_WIDTH(IN_WIDTH + 1), .ACC_WIDTH(ACC_WIDTH)) u_cell1 (
            .clear  (clear),
            .entry  (mem[addr1][l]),
            .addend (add1[l]),
            .result (res1[l])
        );
        acc_lane_sat #(.ADD_WIDTH(IN_WIDTH + 1), .ACC_WIDTH(ACC_WIDTH)) u_cell2 (
            .clear  (clear),
            .entry  (mem[addr2][l]),
            .addend (add2[l]),
            .result (res2[l])
        );
    end

    // Storage carries no reset; frame 0 of every period overwrites it.
    always_ff @(posedge clk) begin
        if (wr1) mem[addr1] <= res1;
        if (wr2) mem[addr2] <= res2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ACCUM;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (accum_beat && frame_end && (frame_q == FW'(N_FRAMES - 1))) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                load_first = 1'b1;
                state_d    = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (ptr_q == LAST_PTR) begin
                        finish  = 1'b1;
                        state_d = ST_ACCUM;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            data_q  <= '0;
            frame_q <= '0;
        end else begin
            if (load_first) begin
                ptr_q  <= '0;
                data_q <= mem[0];
            end else if (advance) begin
                ptr_q  <= ptr_next;
                data_q <= mem[ptr_next];
            end else if (finish) begin
                ptr_q  <= '0;
            end

            if (finish)                       frame_q <= '0;
            else if (accum_beat && frame_end) frame_q <= frame_q + FW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        drop_err <= 1'b0;
        else if (clr_err)  drop_err <= 1'b0;
        else if (drop_set) drop_err <= 1'b1;
    end

    assign out_valid = (state_q == ST_DRAIN);
    assign out_data  = data_q;
    assign out_index = IDX_WIDTH'(ptr_q);
    assign out_last  = out_valid && (ptr_q == LAST_PTR);
    assign frame_cnt = frame_q;

endmodule

// File: tb/tb_power_integrator.sv
// tb/tb_power_integrator.sv - scoreboard bench for power_integrator
module tb_power_integrator;

    localparam int IW = 53;
    localparam int AW = 54;
    localparam int XW = 11;
    localparam int NC = 8;
    localparam int NF = 2;
    localparam int FW = $clog2(NF + 1);

    typedef logic [3:0][IW-1:0] in_vec_t;
    typedef logic [3:0][AW-1:0] acc_vec_t;
    typedef struct {
        int       idx;
        acc_vec_t data;
        bit       last;
    } exp_t;

    logic          clk, rst_n, in_valid, out_valid, out_ready, out_last, drop_err, clr_err;
    in_vec_t       in_col1, in_col2;
    logic [XW-1:0] in_index_col1, in_index_col2, out_index;
    acc_vec_t      out_data;
    logic [FW-1:0] frame_cnt;

    power_integrator #(
        .IN_WIDTH(IW), .ACC_WIDTH(AW), .IDX_WIDTH(XW), .N_COLS(NC), .N_FRAMES(NF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_col1(in_col1), .in_col2(in_col2),
        .in_index_col1(in_index_col1), .in_index_col2(in_index_col2),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last),
        .drop_err(drop_err), .clr_err(clr_err), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    acc_vec_t mdl [NC];
    int       mfc = 0;
    bit       mdrop = 0;
    exp_t     sb[$];

    function automatic in_vec_t fill(input logic [IW-1:0] v);
        in_vec_t r;
        for (int l = 0; l < 4; l++) r[l] = v;
        return r;
    endfunction

    function automatic in_vec_t ramp(input logic [IW-1:0] v);
        in_vec_t r;
        for (int l = 0; l < 4; l++) r[l] = v + IW'(l);
        return r;
    endfunction

    function automatic logic [AW-1:0] msat(input logic [AW+1:0] s);
        logic [AW+1:0] lim;
        lim = {2'b00, {AW{1'b1}}};
        return (s > lim) ? {AW{1'b1}} : s[AW-1:0];
    endfunction

    // Updates the reference model for one accepted beat, then drives it.
    task automatic beat(input int i1, input in_vec_t c1, input int i2, input in_vec_t c2);
        bit ok1, en2, ok2, col;
        logic [AW-1:0] base;
        logic [AW+1:0] s;
        exp_t e;
        ok1 = (i1 < NC);
        en2 = (i1 >= 2);
        ok2 = en2 && (i2 < NC);
        col = ok1 && ok2 && (i1 == i2);
        for (int l = 0; l < 4; l++) begin
            if (ok1) begin
                base = (mfc == 0) ? '0 : mdl[i1][l];
                s = {2'b00, base} + {3'b000, c1[l]} + (col ? {3'b000, c2[l]} : '0);
                mdl[i1][l] = msat(s);
            end
            if (ok2 && !col) begin
                base = (mfc == 0) ? '0 : mdl[i2][l];
                s = {2'b00, base} + {3'b000, c2[l]};
                mdl[i2][l] = msat(s);
            end
        end
        if (!ok1 || (en2 && !ok2)) mdrop = 1;
        if ((ok1 && i1 == NC - 1) || (ok2 && i2 == NC - 1)) begin
            mfc++;
            if (mfc == NF) begin
                for (int c = 0; c < NC; c++) begin
                    e.idx = c; e.data = mdl[c]; e.last = (c == NC - 1);
                    sb.push_back(e);
                end
                mfc = 0;
            end
        end
        in_valid = 1'b1;
        in_col1 = c1; in_col2 = c2;
        in_index_col1 = XW'(i1); in_index_col2 = XW'(i2);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [IW-1:0] v);
        beat(0, fill(v), 0, fill(0));
        beat(1, fill(v), 0, fill(0));
        beat(2, fill(v), 3, fill(v));
        beat(4, fill(v), 5, fill(v));
        beat(6, fill(v), 7, fill(v));
    endtask

    // Drains until the scoreboard empties; optionally injects discarded beats.
    task automatic drain(input bit rnd, input bit drops);
        int cyc;
        cyc = 0;
        while (sb.size() > 0 && cyc < 300) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drops && cyc == 3) begin
                in_valid = 1'b1; in_index_col1 = XW'(NC - 1); in_col1 = fill(99);
            end
            if (drops && cyc == 6) begin
                in_valid = 1'b1; clr_err = 1'b1; in_index_col1 = XW'(0); in_col1 = fill(77);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            clr_err = 1'b0;
            if (drops && cyc == 3) check("drop_in_drain", drop_err, 1);
            if (drops && cyc == 6) check("clr_beats_drop", drop_err, 0);
            cyc++;
        end
        out_ready = 1'b0;
        check("drain_complete", sb.size(), 0);
    endtask

    logic [255:0] held_data;
    logic [XW-1:0] held_idx;
    bit stalled = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                check("stall_data", out_data, held_data);
                check("stall_index", out_index, held_idx);
            end
            stalled = 0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_index", out_index, e.idx);
                    check("out_data", out_data, e.data);
                    check("out_last", out_last, e.last);
                end
            end else if (out_valid) begin
                stalled = 1;
                held_data = out_data;
                held_idx = out_index;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        in_col1 = '0; in_col2 = '0; in_index_col1 = '0; in_index_col2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);
        check("rst_drop_err", drop_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Uniform value 5 over two frames; drain every lane to 10.
        run_frame(5);
        check("frame_cnt_one", frame_cnt, 1);
        run_frame(5);
        check("load_cycle_not_valid", out_valid, 0);
        @(posedge clk); #1;
        check("drain_valid", out_valid, 1);
        check("drain_first_index", out_index, 0);
        check("drain_first_data", out_data, {4{AW'(10)}});
        drain(0, 0);
        check("period_a_frame_cnt", frame_cnt, 0);
        check("period_a_idle", out_valid, 0);
        check("period_a_drop", drop_err, mdrop);

        // Gating, collision, out-of-range index, random backpressure, drops.
        beat(0, ramp(1), 0, fill(0));
        beat(1, ramp(2), 0, fill(0));
        beat(3, fill(4), 3, fill(6));
        beat(2, ramp(3), 4, ramp(4));
        beat(200, fill(9), 4, fill(2));
        check("idx_drop_set", drop_err, mdrop);
        beat(5, ramp(5), 6, ramp(6));
        beat(7, ramp(7), 1, fill(3));
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        mdrop = 0;
        check("clr_err_clears", drop_err, 0);
        beat(1, ramp(2), 5, fill(7));
        beat(3, fill(4), 3, fill(6));
        beat(0, ramp(1), 0, fill(0));
        beat(2, ramp(3), 4, ramp(4));
        beat(5, ramp(5), 6, ramp(6));
        beat(6, ramp(1), 7, ramp(1));
        drain(1, 1);
        check("period_b_frame_cnt", frame_cnt, 0);

        // Saturation via collisions of all-ones words.
        beat(2, fill('1), 2, fill('1));
        beat(0, fill(1), 0, fill(0));
        beat(1, fill(1), 0, fill(0));
        beat(3, fill(1), 4, fill(1));
        beat(5, fill(1), 6, fill(1));
        beat(7, fill('1), 6, fill(1));
        beat(2, fill('1), 2, fill('1));
        beat(7, fill('1), 5, fill('1));
        drain(0, 0);
        check("period_c_frame_cnt", frame_cnt, 0);

        // Reset while index 3 is presented, then a fresh period.
        run_frame(9);
        run_frame(9);
        out_ready = 1'b1;
        cyc = 0;
        while (!(out_valid && out_index == XW'(3)) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        check("reach_index_3", out_index, 3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_index", out_index, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_frame_cnt", frame_cnt, 0);
        sb.delete();
        mfc = 0;
        mdrop = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(3);
        run_frame(3);
        drain(1, 0);
        check("period_d_frame_cnt", frame_cnt, 0);
        check("period_d_drop", drop_err, mdrop);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/power_integrator.md
# power_integrator

Receiving end of the 4-lane power-stage output stream. Takes the per-column power words and column indices the power stage emits with its output strobe, and accumulates them per column and per lane over N_FRAMES frames into a register-file accumulator. When the integration period completes, it drains one accumulated column per beat to the downstream consumer on a valid/ready handshake, then starts the next integration period.

## Interface
- IN_WIDTH, 53, power word width per lane (unsigned magnitude).
- ACC_WIDTH, 64, accumulator and output width per lane.
- IDX_WIDTH, 11, column index width.
- N_COLS, 64, columns per frame; power of 2, at most 2**IDX_WIDTH.
- N_FRAMES, 16, frames per integration period; at least 1.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  beat strobe, driven by the power stage's output strobe. There is no backpressure.
- in_col1  in  [3:0][IN_WIDTH]  4-lane power for column in_index_col1.
- in_col2  in  [3:0][IN_WIDTH]  4-lane power for column in_index_col2.
- in_index_col1  in  IDX_WIDTH  column index of in_col1.
- in_index_col2  in  IDX_WIDTH  column index of in_col2.
- out_valid  out  1  drain beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  [3:0][ACC_WIDTH]  accumulated 4-lane power of column out_index.
- out_index  out  IDX_WIDTH  column being drained.
- out_last  out  1  asserted with column N_COLS-1.
- drop_err  out  1  sticky; a beat was discarded.
- clr_err  in  1  synchronous clear of drop_err.
- frame_cnt  out  $clog2(N_FRAMES+1)  frames completed in the current period.

## Operation
- Storage is N_COLS×4 accumulators of ACC_WIDTH bits. It needs no reset.
- The FSM has three states: ACCUM, LOAD, DRAIN. Reset state is ACCUM with frame_cnt=0.
- **ACCUM, on in_valid:** each input column is read-modify-written.
  - If frame_cnt==0, the entry is overwritten with the zero-extended input. This is the implicit clear.
  - Otherwise the input is added to the entry, saturating at 2**ACC_WIDTH-1 per lane.
- **col2 gating:** col2 is ignored when in_index_col1 < 2, because the upstream stage zeroes it there.
- **Index collision:** if both indices are valid and equal, the per-lane sum col1+col2 is applied once, with the same overwrite/saturation rules.
- **Out-of-range index:** an index >= N_COLS is ignored for that column and sets drop_err.
- **Frame end:** an accepted beat whose in_index_col1 or in_index_col2 equals N_COLS-1 ends the frame and increments frame_cnt.
  - If the increment reaches N_FRAMES, the FSM goes to LOAD.
- **LOAD (1 cycle):** the output register is loaded with entry 0 and the drain pointer is set to 0. The FSM goes to DRAIN.
- **DRAIN:** out_valid=1. out_data, out_index and out_last stay stable until out_valid & out_ready.
  - On a handshake with the pointer below N_COLS-1, the pointer increments and the next entry loads in the same edge, so back-to-back beats are possible.
  - On the handshake with out_last, the FSM returns to ACCUM with frame_cnt=0.
- **Beats outside ACCUM:** in_valid in LOAD or DRAIN is discarded and sets drop_err.
- **drop_err:** clr_err has priority over a new set in the same cycle.

## Timing
- **Reset values:** out_valid=0, out_data=0, out_index=0, out_last=0, drop_err=0, frame_cnt=0.
- **Accumulation latency:** the entry is updated at the edge that samples in_valid. The next beat may read the updated value, so there is no hazard for back-to-back beats to the same column.
- **Frame-end beat sampled at edge E:**
  - state=LOAD after E;
  - out_valid=1 after E+1, and out_data includes that final beat.
- **Minimum drain:** N_COLS cycles with out_ready held at 1.
- **Reset mid-DRAIN or mid-LOAD:** returns immediately to ACCUM with frame_cnt=0 and outputs cleared. Stale storage is overwritten by the next frame 0.

## Structure
- Package `integrator_pkg` holds:
  - the FSM state enum;
  - the lane-count constant (4);
  - a lane-vector typedef of ACC_WIDTH words;
  - a sat_add function.
- Sub-module `acc_lane_sat`: per-lane overwrite-or-saturating-add combinational cell, instantiated 4×2.

## Test plan
- N_COLS=8, N_FRAMES=2: feed columns 0..7 (col1 only for indices 0/1, then pairs) with every lane =5, for two frames.
  - Required: drain of 8 beats, every lane 10, out_last on index 7, frame_cnt back to 0.
- Saturation: preload by frames of lane value 2**IN_WIDTH-1 with ACC_WIDTH=IN_WIDTH+1, 4 frames.
  - Required: out_data = 2**ACC_WIDTH-1.
- col2 gating and collision:
  - in_index_col1=1 with col2=7: col2 is not accumulated.
  - indices 3 and 3 with col1=4, col2=6: entry 3 = 10.
- Backpressure: toggle out_ready randomly during drain.
  - Required: out_data and out_index stable while stalled, no skipped or duplicated index.
- Drop: in_valid during DRAIN, and index 200 in ACCUM.
  - Required: drop_err=1, accumulators unchanged.
  - clr_err clears it; clr_err coincident with a drop leaves 0.
- Reset asserted mid-DRAIN at index 3.
  - Required: all outputs 0 next cycle; the next full period drains fresh values with no stale carry-over.
